id_stage: RTL and testbench

Instruction-decode stage of the pipelined CPU. Takes the fetched instruction from IF/ID, drives the register-file read addresses, decodes control, detects load-use hazards, and registers operands plus control into the ID/EX pipeline register consumed by the execute stage. Sits directly upstream of the register file's read ports and of EX.

---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/id_decode.sv | 75 +++++++
 rtl/id_stage.sv | 156 +++++++++++++++
 tb/tb_id_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, opcode/funct values,
// ALU operation encodings and the decoded-control bundle.
package cpu_pkg;

    // Instruction field bit positions
    localparam int unsigned OpcHi   = 31;
    localparam int unsigned OpcLo   = 26;
    localparam int unsigned RsHi    = 25;
    localparam int unsigned RsLo    = 21;
    localparam int unsigned RtHi    = 20;
    localparam int unsigned RtLo    = 16;
    localparam int unsigned RdHi    = 15;
    localparam int unsigned RdLo    = 11;
    localparam int unsigned FunctHi = 5;
    localparam int unsigned FunctLo = 0;
    localparam int unsigned ImmHi   = 15;
    localparam int unsigned ImmLo   = 0;

    // Instruction register fields are always 5 bits wide
    localparam int unsigned RegFieldW = 5;

    // Opcodes
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluAnd = 3'd2,
        AluOr  = 3'd3,
        AluSlt = 3'd4
    } aluop_e;

    // Decoded control for one instruction. uses_rt marks formats that read rt
    // as a source (R-type, SW, BEQ) and feeds only the load-use check.
    typedef struct packed {
        logic                 regwrite;
        logic                 memread;
        logic                 memwrite;
        logic                 branch;
        logic                 alusrc;
        logic                 illegal;
        aluop_e               aluop;
        logic [RegFieldW-1:0] wa;
        logic                 uses_rt;
    } ctrl_t;

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decoder: instruction word to control bundle.
module id_decode
    import cpu_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl
);

    logic [5:0]           w_opcode;
    logic [5:0]           w_funct;
    logic [RegFieldW-1:0] w_rt;
    logic [RegFieldW-1:0] w_rd;
    ctrl_t                w_ctrl;

    assign w_opcode = i_instr[OpcHi:OpcLo];
    assign w_funct  = i_instr[FunctHi:FunctLo];
    assign w_rt     = i_instr[RtHi:RtLo];
    assign w_rd     = i_instr[RdHi:RdLo];

    // Decode opcode/funct into control; illegal encodings keep only the illegal flag
    always_comb begin
        w_ctrl       = '0;
        w_ctrl.aluop = AluAdd;
        case (w_opcode)
            OpRtype: begin
                w_ctrl.uses_rt  = 1'b1;
                w_ctrl.regwrite = 1'b1;
                w_ctrl.wa       = w_rd;
                case (w_funct)
                    FnAdd:   w_ctrl.aluop = AluAdd;
                    FnSub:   w_ctrl.aluop = AluSub;
                    FnAnd:   w_ctrl.aluop = AluAnd;
                    FnOr:    w_ctrl.aluop = AluOr;
                    FnSlt:   w_ctrl.aluop = AluSlt;
                    default: w_ctrl.illegal = 1'b1;
                endcase
            end
            OpAddi: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.alusrc   = 1'b1;
                w_ctrl.wa       = w_rt;
            end
            OpLw: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.memread  = 1'b1;
                w_ctrl.alusrc   = 1'b1;
                w_ctrl.wa       = w_rt;
            end
            OpSw: begin
                w_ctrl.memwrite = 1'b1;
                w_ctrl.alusrc   = 1'b1;
                w_ctrl.uses_rt  = 1'b1;
            end
            OpBeq: begin
                w_ctrl.branch  = 1'b1;
                w_ctrl.aluop   = AluSub;
                w_ctrl.uses_rt = 1'b1;
            end
            default: w_ctrl.illegal = 1'b1;
        endcase

        if (w_ctrl.illegal) begin
            w_ctrl.regwrite = 1'b0;
            w_ctrl.aluop    = AluAdd;
            w_ctrl.wa       = '0;
        end
        // r0 is hardwired; never request a write to it
        if (w_ctrl.wa == '0) begin
            w_ctrl.regwrite = 1'b0;
        end
    end

    assign o_ctrl = w_ctrl;

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: register-file addressing, decode, load-use hazard
// detection and the ID/EX pipeline register.
module id_stage
    import cpu_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned R = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         if_valid,
    input  logic [31:0]  if_instr,
    input  logic [N-1:0] if_pc,
    input  logic         flush,
    input  logic         ex_hold,
    output logic         id_stall,
    output logic [R-1:0] raA,
    output logic [R-1:0] raB,
    input  logic [N-1:0] rdA,
    input  logic [N-1:0] rdB,
    output logic         ex_valid,
    output logic         ex_regwrite,
    output logic         ex_memread,
    output logic         ex_memwrite,
    output logic         ex_branch,
    output logic         ex_alusrc,
    output logic         ex_illegal,
    output logic [2:0]   ex_aluop,
    output logic [N-1:0] ex_pc,
    output logic [N-1:0] ex_a,
    output logic [N-1:0] ex_b,
    output logic [N-1:0] ex_imm,
    output logic [R-1:0] ex_rs,
    output logic [R-1:0] ex_rt,
    output logic [R-1:0] ex_wa,
    output logic [31:0]  stall_count
);

    typedef struct packed {
        logic         valid;
        logic         regwrite;
        logic         memread;
        logic         memwrite;
        logic         branch;
        logic         alusrc;
        logic         illegal;
        logic [2:0]   aluop;
        logic [N-1:0] pc;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] imm;
        logic [R-1:0] rs;
        logic [R-1:0] rt;
        logic [R-1:0] wa;
    } idex_t;

    ctrl_t        w_ctrl;
    logic [R-1:0] w_rs;
    logic [R-1:0] w_rt;
    logic [N-1:0] w_imm_ext;
    logic         w_hazard;
    logic         w_load_use;
    logic         w_upd;
    idex_t        w_idex_d;
    idex_t        r_idex;
    logic [31:0]  r_stall_count;
    logic [31:0]  w_stall_count_d;

    id_decode u_decode (
        .i_instr (if_instr),
        .o_ctrl  (w_ctrl)
    );

    assign w_rs      = R'(if_instr[RsHi:RsLo]);
    assign w_rt      = R'(if_instr[RtHi:RtLo]);
    assign w_imm_ext = {{(N-16){if_instr[ImmHi]}}, if_instr[ImmHi:ImmLo]};

    assign raA = w_rs;
    assign raB = w_rt;

    // A load in EX whose target is read by the instruction in ID must stall one cycle
    assign w_hazard = if_valid && r_idex.valid && r_idex.memread && (r_idex.rt != '0) &&
                      ((r_idex.rt == w_rs) || (w_ctrl.uses_rt && (r_idex.rt == w_rt)));

    // flush squashes ID, so neither a hold nor a hazard can stall IF that cycle
    assign id_stall   = !flush && (ex_hold || w_hazard);
    assign w_load_use = !flush && !ex_hold && w_hazard;

    // Next ID/EX contents: flush, hold, load-use bubble, then normal issue
    always_comb begin
        w_idex_d = '0;
        w_upd    = 1'b1;
        if (flush) begin
            w_idex_d = '0;
        end else if (ex_hold) begin
            w_upd = 1'b0;
        end else if (w_hazard) begin
            w_idex_d = '0;
        end else if (if_valid) begin
            w_idex_d.valid    = 1'b1;
            w_idex_d.regwrite = w_ctrl.regwrite;
            w_idex_d.memread  = w_ctrl.memread;
            w_idex_d.memwrite = w_ctrl.memwrite;
            w_idex_d.branch   = w_ctrl.branch;
            w_idex_d.alusrc   = w_ctrl.alusrc;
            w_idex_d.illegal  = w_ctrl.illegal;
            w_idex_d.aluop    = w_ctrl.aluop;
            w_idex_d.pc       = if_pc;
            w_idex_d.a        = rdA;
            w_idex_d.b        = rdB;
            w_idex_d.imm      = w_imm_ext;
            w_idex_d.rs       = w_rs;
            w_idex_d.rt       = w_rt;
            w_idex_d.wa       = R'(w_ctrl.wa);
        end
    end

    // Saturating stall counter next value
    always_comb begin
        w_stall_count_d = r_stall_count;
        if (w_load_use && (r_stall_count != '1)) begin
            w_stall_count_d = r_stall_count + 32'd1;
        end
    end

    // ID/EX pipeline register and stall counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idex        <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_upd) begin
                r_idex <= w_idex_d;
            end
            r_stall_count <= w_stall_count_d;
        end
    end

    assign ex_valid    = r_idex.valid;
    assign ex_regwrite = r_idex.regwrite;
    assign ex_memread  = r_idex.memread;
    assign ex_memwrite = r_idex.memwrite;
    assign ex_branch   = r_idex.branch;
    assign ex_alusrc   = r_idex.alusrc;
    assign ex_illegal  = r_idex.illegal;
    assign ex_aluop    = r_idex.aluop;
    assign ex_pc       = r_idex.pc;
    assign ex_a        = r_idex.a;
    assign ex_b        = r_idex.b;
    assign ex_imm      = r_idex.imm;
    assign ex_rs       = r_idex.rs;
    assign ex_rt       = r_idex.rt;
    assign ex_wa       = r_idex.wa;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus random traffic
// checked against a behavioural model of the decode stage.
module tb_id_stage;

    logic        clock;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        ex_hold;
    logic        id_stall;
    logic [4:0]  raA;
    logic [4:0]  raB;
    logic [31:0] rdA;
    logic [31:0] rdB;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
    logic        ex_branch, ex_alusrc, ex_illegal;
    logic [2:0]  ex_aluop;
    logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_wa;
    logic [31:0] stall_count;

    id_stage #(.N(32), .R(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .flush       (flush),
        .ex_hold     (ex_hold),
        .id_stall    (id_stall),
        .raA         (raA),
        .raB         (raB),
        .rdA         (rdA),
        .rdB         (rdB),
        .ex_valid    (ex_valid),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .ex_memwrite (ex_memwrite),
        .ex_branch   (ex_branch),
        .ex_alusrc   (ex_alusrc),
        .ex_illegal  (ex_illegal),
        .ex_aluop    (ex_aluop),
        .ex_pc       (ex_pc),
        .ex_a        (ex_a),
        .ex_b        (ex_b),
        .ex_imm      (ex_imm),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_wa       (ex_wa),
        .stall_count (stall_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic        last_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference decode result for one instruction word
    typedef struct {
        bit         rw, mr, mw, br, as, il, use_rt, wa_chk;
        logic [2:0] aluop;
        logic [4:0] wa;
    } ref_t;

    function automatic ref_t ref_decode(input logic [31:0] ins);
        ref_t       d;
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] fn_tab [5];
        bit         found;
        op = ins[31:26];
        fn = ins[5:0];
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        d = '{default: 0};
        if (op == 6'h00) begin
            d.use_rt = 1;
            found = 0;
            for (int k = 0; k < 5; k++) begin
                if (fn == fn_tab[k]) begin
                    found   = 1;
                    d.aluop = 3'(k);
                end
            end
            if (!found) d.il = 1;
            else begin
                d.wa = ins[15:11]; d.wa_chk = 1; d.rw = (d.wa != 0);
            end
        end else if (op == 6'h08 || op == 6'h23) begin
            d.as = 1; d.wa = ins[20:16]; d.wa_chk = 1; d.rw = (d.wa != 0);
            d.mr = (op == 6'h23);
        end else if (op == 6'h2B) begin
            d.mw = 1; d.as = 1; d.use_rt = 1;
        end else if (op == 6'h04) begin
            d.br = 1; d.aluop = 3'd1; d.use_rt = 1;
        end else begin
            d.il = 1;
        end
        return d;
    endfunction

    // Model of what EX currently holds
    bit          m_valid;
    ref_t        m_d;
    logic [31:0] m_pc, m_a, m_b, m_imm;
    logic [4:0]  m_rs, m_rt;
    logic [31:0] m_cnt;

    task automatic model_reset();
        m_valid = 0;
        m_d     = '{default: 0};
        m_cnt   = 0;
    endtask

    function automatic logic [9:0] model_ctrl();
        return {m_valid, m_d.rw, m_d.mr, m_d.mw, m_d.br, m_d.as, m_d.il, m_d.aluop};
    endfunction

    task automatic check_state();
        check("ctrl", {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_alusrc,
                       ex_illegal, ex_aluop}, model_ctrl());
        check("stall_count", stall_count, m_cnt);
        if (m_valid) begin
            check("ex_pc", ex_pc, m_pc);
            check("ex_a", ex_a, m_a);
            check("ex_b", ex_b, m_b);
            check("ex_imm", ex_imm, m_imm);
            check("ex_rs", ex_rs, m_rs);
            check("ex_rt", ex_rt, m_rt);
            if (m_d.wa_chk) check("ex_wa", ex_wa, m_d.wa);
        end
    endtask

    // One pipeline cycle: drive after negedge, check combinational outputs,
    // advance model at posedge and check registered state just after it.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic hd, input logic [31:0] a,
                         input logic [31:0] b);
        ref_t d;
        bit   haz;
        bit   exp_stall;
        @(negedge clock);
        if_valid = v; if_instr = ins; if_pc = pc; flush = fl; ex_hold = hd;
        rdA = a; rdB = b;
        #1;
        d = ref_decode(ins);
        haz = v && m_valid && m_d.mr && (m_rt != 0) &&
              ((m_rt == ins[25:21]) || (d.use_rt && (m_rt == ins[20:16])));
        exp_stall = !fl && (hd || haz);
        check("id_stall", id_stall, exp_stall);
        check("raA", raA, ins[25:21]);
        check("raB", raB, ins[20:16]);
        last_stall = id_stall;
        @(posedge clock);
        if (fl) begin
            m_valid = 0; m_d = '{default: 0};
        end else if (hd) begin
            // EX frozen
        end else if (haz) begin
            m_valid = 0; m_d = '{default: 0};
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else if (v) begin
            m_valid = 1; m_d = d; m_pc = pc; m_a = a; m_b = b;
            m_imm = {{16{ins[15]}}, ins[15:0]};
            m_rs = ins[25:21]; m_rt = ins[20:16];
        end else begin
            m_valid = 0; m_d = '{default: 0};
        end
        #1;
        check_state();
    endtask

    // Asynchronous reset pulse away from any clock edge
    task automatic reset_pulse();
        #2;
        flush = 0; ex_hold = 0;
        reset = 0;
        #1;
        model_reset();
        check("rst_ctrl", {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
                           ex_alusrc, ex_illegal, ex_aluop}, 32'd0);
        check("rst_cnt", stall_count, 32'd0);
        check("rst_data", ex_pc | ex_a | ex_b | ex_imm | {17'd0, ex_rs, ex_rt, ex_wa}, 32'd0);
        check("rst_stall", id_stall, 1'b0);
        @(negedge clock);
        reset = 1;
    endtask

    localparam logic [31:0] AddR3R1R2 = 32'h0022_1820;
    localparam logic [31:0] LwR2R1    = 32'h8C22_0004;
    localparam logic [31:0] AddR3R2R4 = 32'h0044_1820;
    localparam logic [31:0] AddiR2R5  = 32'h20A2_0001;
    localparam logic [31:0] LwR0R1    = 32'h8C20_0000;
    localparam logic [31:0] AddR3R0R0 = 32'h0000_1820;
    localparam logic [31:0] IllegalOp = 32'hFC00_0000;
    localparam logic [31:0] BeqNeg4   = 32'h1022_FFFC;

    function automatic logic [31:0] rand_instr();
        logic [5:0]  fn_tab [5];
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  fn;
        int unsigned sel;
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2: begin
                fn = fn_tab[$urandom_range(0, 4)];
                return {6'h00, rs, rt, rd, 5'd0, fn};
            end
            3: op = 6'h08;
            4, 5: op = 6'h23;
            6: op = 6'h2B;
            7: op = 6'h04;
            8: return $urandom;
            default: return {6'h00, rs, rt, rd, 5'd0, 6'($urandom)};
        endcase
        return {op, rs, rt, 16'($urandom)};
    endfunction

    initial begin
        reset = 1; if_valid = 0; if_instr = 0; if_pc = 0; flush = 0; ex_hold = 0;
        rdA = 0; rdB = 0; last_stall = 0;
        model_reset();
        reset_pulse();

        // Basic ADD
        drive(1, AddR3R1R2, 32'h100, 0, 0, 5, 7);
        check("add_valid", ex_valid, 1);
        check("add_regwrite", ex_regwrite, 1);
        check("add_aluop", ex_aluop, 0);
        check("add_a", ex_a, 5);
        check("add_b", ex_b, 7);
        check("add_wa", ex_wa, 3);

        // Load-use stall for exactly one cycle
        drive(1, LwR2R1, 32'h104, 0, 0, 1, 2);
        drive(1, AddR3R2R4, 32'h108, 0, 0, 9, 9);
        check("lu_stall", last_stall, 1);
        check("lu_bubble", ex_valid, 0);
        drive(1, AddR3R2R4, 32'h108, 0, 0, 11, 12);
        check("lu_release", last_stall, 0);
        check("lu_issue", ex_valid, 1);
        check("lu_count", stall_count, 1);

        // ADDI writing the load target, and load to r0: no stall
        drive(1, LwR2R1, 32'h10C, 0, 0, 1, 2);
        drive(1, AddiR2R5, 32'h110, 0, 0, 3, 4);
        check("addi_nostall", last_stall, 0);
        drive(1, LwR0R1, 32'h114, 0, 0, 1, 2);
        drive(1, AddR3R0R0, 32'h118, 0, 0, 0, 0);
        check("r0_nostall", last_stall, 0);

        // Flush beats a load-use hazard
        drive(1, LwR2R1, 32'h11C, 0, 0, 1, 2);
        drive(1, AddR3R2R4, 32'h120, 1, 0, 6, 6);
        check("flush_stall", last_stall, 0);
        check("flush_bubble", ex_valid, 0);
        check("flush_count", stall_count, 1);

        // Hold for three cycles freezes EX
        drive(1, AddR3R1R2, 32'h124, 0, 0, 5, 7);
        for (int k = 0; k < 3; k++) begin
            drive(1, LwR2R1, 32'h128, 0, 1, 99, 98);
            check("hold_stall", last_stall, 1);
            check("hold_a", ex_a, 5);
        end
        // Flush with hold still squashes
        drive(1, AddR3R1R2, 32'h12C, 1, 1, 1, 1);
        check("flush_hold", ex_valid, 0);

        // Illegal opcode and BEQ immediate
        drive(1, IllegalOp, 32'h130, 0, 0, 0, 0);
        check("ill_flag", ex_illegal, 1);
        check("ill_valid", ex_valid, 1);
        check("ill_ctrl", {ex_regwrite, ex_memwrite}, 0);
        drive(1, BeqNeg4, 32'h134, 0, 0, 3, 3);
        check("beq_imm", ex_imm, 32'hFFFF_FFFC);
        check("beq_branch", ex_branch, 1);
        check("beq_aluop", ex_aluop, 1);

        // Reset during a load-use stall, then normal decode
        drive(1, LwR2R1, 32'h138, 0, 0, 1, 2);
        @(negedge clock);
        if_instr = AddR3R2R4; flush = 0; ex_hold = 0; if_valid = 1;
        #1 check("pre_rst_stall", id_stall, 1);
        reset_pulse();
        drive(1, AddR3R1R2, 32'h200, 0, 0, 5, 7);
        check("post_rst_valid", ex_valid, 1);
        check("post_rst_a", ex_a, 5);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 7) != 0), rand_instr(), $urandom,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                  $urandom, $urandom);
            if (i == 700) reset_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
